decode_stage: RTL and testbench
===============================

# decode_stage

Pipelined MIPS instruction-decode stage: the consumer of the 64-bit IF/ID word produced by the fetch stage, and the producer of the ID/EX register consumed by the execute stage. It decodes the instruction, reads a 32×32 register file that the write-back stage updates through a dedicated port, and sign-extends the immediate. It also detects load-use hazards, stalling fetch and inserting a bubble, and squashes its output on a taken-branch flush.

## Interface
Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width (32 registers).

Ports:
- clk  in  1  rising-edge clock; the block uses one clock only.
- rst_n  in  1  asynchronous, active-low reset.
- if_id  in  64  [63:32] PC+4, [31:0] instruction.
- flush  in  1  taken branch resolved downstream; squash the current decode.
- wb_reg_write  in  1  write-back enable.
- wb_rd  in  5  write-back destination register.
- wb_data  in  32  write-back data.
- stall  out  1  to fetch: hold the PC and IF/ID this cycle.
- id_ex_wb  out  2  {RegWrite, MemToReg}.
- id_ex_m  out  3  {Branch, MemRead, MemWrite}.
- id_ex_ex  out  4  {RegDst, ALUOp[1:0], ALUSrc}.
- id_ex_pc4  out  32  registered PC+4.
- id_ex_rs_data, id_ex_rt_data  out  32 each  register operands.
- id_ex_imm  out  32  sign-extended instr[15:0].
- id_ex_rs, id_ex_rt, id_ex_rd  out  5 each  instr[25:21], [20:16], [15:11].

## Operation
- Control decode (opcode = instr[31:26]). Each row gives wb / m / ex:
  - 0x00 R-type: 10 / 000 / 1100.
  - 0x23 lw: 11 / 010 / 0001.
  - 0x2B sw: 00 / 001 / 0001.
  - 0x04 beq: 00 / 100 / 0010.
  - 0x08 addi: 10 / 000 / 0001.
  - Any other opcode: all zero (NOP).
- Register file:
  - 32 entries; r0 always reads 0.
  - A write occurs at posedge when wb_reg_write=1 and wb_rd≠0.
  - Write-through bypass: if a read address equals wb_rd with a valid write in the same cycle, the read returns wb_data.
- Load-use hazard:
  - Condition: hazard = id_ex_m[1] (MemRead) & (id_ex_rt≠0) & ((id_ex_rt==rs) | (uses_rt & id_ex_rt==rt)).
  - uses_rt=1 for R-type, sw and beq; uses_rt=0 for lw, addi and NOP.
- stall = hazard & ~flush. This is combinational from the registered ID/EX fields and the IF/ID input.
- ID/EX update at each posedge:
  - If flush or stall: wb, m and ex load 0 (bubble). All other fields load normally.
  - Otherwise: all fields load from the decode.
- Arithmetic: id_ex_imm = {{16{instr[15]}}, instr[15:0]}. No other arithmetic is performed.

## Timing
- Latency: if_id to id_ex_* is 1 cycle. A register-file write becomes visible to a same-cycle read via the bypass and is stored at the same posedge.
- Load-use stalls last exactly 1 cycle, because the bubble clears id_ex_m[1] on the next edge. A back-to-back lw followed by a dependent lw also stalls once.
- Simultaneous flush and hazard: flush wins, stall=0, and a bubble is issued.
- Reset while rst_n=0, effective immediately:
  - All id_ex_* outputs are 0.
  - All 32 registers are 0.
  - stall=0.
- Reset mid-stall: stall drops in the same cycle as reset assertion, since it derives from the cleared ID/EX.
- Instruction 0x00000000 decodes as an R-type writing r0 and is architecturally a NOP.

## Structure
- Package mips_pkg holds:
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI).
  - Control bundle widths (WB_W=2, M_W=3, EX_W=4).
  - IF/ID field offsets.
- Sub-module decode_regfile: two asynchronous read ports, one synchronous write port, async active-low clear, r0 hardwired, and the write-through bypass.
- Control decode and hazard detection are inline in decode_stage.

## Test plan
- Reset: assert rst_n=0 mid-run → all id_ex_* = 0, stall=0, and reads of r1..r31 return 0 after release.
- Write-back and bypass:
  - Stimulus: wb_rd=5, wb_data=0xDEADBEEF, with if_id instruction add $3,$5,$6 (0x00A61820) in the same cycle.
  - Required: next cycle id_ex_rs_data=0xDEADBEEF and id_ex_ex=1100.
  - Also: a write to r0 with 0x1234 leaves r0 reading 0.
- Load-use:
  - Stimulus: lw $2,4($1) (0x8C220004) followed by add $4,$2,$3 (0x00432020).
  - Required: stall=1 for exactly one cycle, the ID/EX after the lw carries all-zero control, and the add then issues with id_ex_rs=2.
- No false stall:
  - lw $2,… followed by addi $2,$7,5 (0x20E20005) → stall stays 0.
  - lw $0,… followed by add $4,$0,$3 → stall stays 0.
- Flush priority: flush=1 in the same cycle as a load-use hazard → stall=0, and the next id_ex wb/m/ex are 000.
- Sign extension and unknown opcode:
  - addi with imm 0xFFFC → id_ex_imm = 0xFFFFFFFC.
  - Opcode 0x3F → all control 0.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS decode stage:
//   - opcode constants for the supported instruction subset
//   - widths of the WB / M / EX control bundles carried into ID/EX
//   - bit offsets of the fields inside the 64-bit IF/ID word
//   - the control bundle struct and the opcode decode helpers
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    // MemRead position inside the {Branch, MemRead, MemWrite} bundle
    localparam int M_MEMREAD = 1;

    // IF/ID word layout: [63:32] PC+4, [31:0] instruction
    localparam int IFID_PC4_LSB   = 32;
    localparam int IFID_INSTR_LSB = 0;

    // Instruction field offsets (within the 32-bit instruction)
    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_W   = 16;

    typedef struct packed {
        logic [WB_W-1:0] wb;   // {RegWrite, MemToReg}
        logic [M_W-1:0]  m;    // {Branch, MemRead, MemWrite}
        logic [EX_W-1:0] ex;   // {RegDst, ALUOp[1:0], ALUSrc}
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{wb: '0, m: '0, ex: '0};

    // Main control table; unknown opcodes fall back to an all-zero bundle
    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c = CTRL_NOP;
        case (op)
            OP_RTYPE: c = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
            OP_LW:    c = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
            OP_SW:    c = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
            OP_BEQ:   c = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
            OP_ADDI:  c = '{wb: 2'b10, m: 3'b000, ex: 4'b0001};
            default:  c = CTRL_NOP;
        endcase
        return c;
    endfunction

    // True when the instruction actually consumes rt as a source operand
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
// Bundles everything the decode stage exchanges with its neighbours:
//   if_id         in   64  {PC+4, instruction} from fetch
//   flush         in   1   taken branch resolved downstream
//   wb_reg_write  in   1   write-back enable
//   wb_rd         in   5   write-back destination
//   wb_data       in   32  write-back data
//   stall         out  1   hold PC and IF/ID in fetch
//   id_ex_*       out  -   ID/EX pipeline register toward execute
// The slave modport is the decode stage; master is its environment.
// ---------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    import mips_pkg::*;

    logic [2*DATA_W-1:0] if_id;
    logic                flush;
    logic                wb_reg_write;
    logic [REG_AW-1:0]   wb_rd;
    logic [DATA_W-1:0]   wb_data;

    logic                stall;
    logic [WB_W-1:0]     id_ex_wb;
    logic [M_W-1:0]      id_ex_m;
    logic [EX_W-1:0]     id_ex_ex;
    logic [DATA_W-1:0]   id_ex_pc4;
    logic [DATA_W-1:0]   id_ex_rs_data;
    logic [DATA_W-1:0]   id_ex_rt_data;
    logic [DATA_W-1:0]   id_ex_imm;
    logic [REG_AW-1:0]   id_ex_rs;
    logic [REG_AW-1:0]   id_ex_rt;
    logic [REG_AW-1:0]   id_ex_rd;

    modport master (
        output if_id, flush, wb_reg_write, wb_rd, wb_data,
        input  stall, id_ex_wb, id_ex_m, id_ex_ex, id_ex_pc4,
               id_ex_rs_data, id_ex_rt_data, id_ex_imm,
               id_ex_rs, id_ex_rt, id_ex_rd
    );

    modport slave (
        input  if_id, flush, wb_reg_write, wb_rd, wb_data,
        output stall, id_ex_wb, id_ex_m, id_ex_ex, id_ex_pc4,
               id_ex_rs_data, id_ex_rt_data, id_ex_imm,
               id_ex_rs, id_ex_rt, id_ex_rd
    );

endinterface

// File: rtl/decode_regfile.sv
// ---------------------------------------------------------------------------
// decode_regfile
// 32 x 32 register file for the decode stage.
//   clk, rst_n      clock, async active-low clear of all entries
//   we_i            write enable from write-back
//   waddr_i/wdata_i write address / data (stored at posedge)
//   raddr_a_i/b_i   asynchronous read addresses
//   rdata_a_o/b_o   read data; r0 reads 0, a same-cycle write to the
//                   addressed register is forwarded straight through
// ---------------------------------------------------------------------------
module decode_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] mem_q [NREG];
    logic              wr_valid;

    // A write to r0 is discarded so it can neither be stored nor bypassed
    assign wr_valid = we_i && (waddr_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_valid) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Write-through lets write-back and decode share a cycle without a
    // separate forwarding path in execute
    function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (wr_valid && (addr == waddr_i)) begin
            return wdata_i;
        end else begin
            return mem_q[addr];
        end
    endfunction

    assign rdata_a_o = read_port(raddr_a_i);
    assign rdata_b_o = read_port(raddr_b_i);

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// MIPS instruction-decode stage: control decode, register-file read,
// immediate sign-extension, load-use hazard detection and branch flush.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    decode_stage_if.slave: IF/ID word, flush, write-back port in;
//          stall to fetch and the ID/EX register out
// ---------------------------------------------------------------------------
module decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);

    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] rs_data, rt_data;
    ctrl_t             ctrl;
    logic              hazard;
    logic              stall;
    logic              bubble;

    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic [REG_AW-1:0] rd_q, rd_d;

    assign instr  = bus.if_id[IFID_INSTR_LSB +: 32];
    assign opcode = instr[OPC_LSB +: 6];
    assign rs     = instr[RS_LSB +: REG_AW];
    assign rt     = instr[RT_LSB +: REG_AW];
    assign rd     = instr[RD_LSB +: REG_AW];
    assign ctrl   = decode_ctrl(opcode);

    decode_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (bus.wb_reg_write),
        .waddr_i   (bus.wb_rd),
        .wdata_i   (bus.wb_data),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rs_data),
        .rdata_b_o (rt_data)
    );

    // A load in ID/EX whose target feeds this instruction cannot be
    // forwarded in time; hazard looks only at registered ID/EX state so the
    // bubble it causes removes the hazard on the following cycle
    assign hazard = ctrl_q.m[M_MEMREAD] && (rt_q != '0) &&
                    ((rt_q == rs) || (uses_rt(opcode) && (rt_q == rt)));

    // A flush discards this instruction anyway, so holding fetch is pointless
    assign stall  = hazard && !bus.flush;
    assign bubble = bus.flush || stall;

    always_comb begin
        ctrl_d    = bubble ? CTRL_NOP : ctrl;
        pc4_d     = bus.if_id[IFID_PC4_LSB +: DATA_W];
        rs_data_d = rs_data;
        rt_data_d = rt_data;
        imm_d     = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
        rs_d      = rs;
        rt_d      = rt;
        rd_d      = rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= CTRL_NOP;
            pc4_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            pc4_q     <= pc4_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
        end
    end

    assign bus.stall         = stall;
    assign bus.id_ex_wb      = ctrl_q.wb;
    assign bus.id_ex_m       = ctrl_q.m;
    assign bus.id_ex_ex      = ctrl_q.ex;
    assign bus.id_ex_pc4     = pc4_q;
    assign bus.id_ex_rs_data = rs_data_q;
    assign bus.id_ex_rt_data = rt_data_q;
    assign bus.id_ex_imm     = imm_q;
    assign bus.id_ex_rs      = rs_q;
    assign bus.id_ex_rt      = rt_q;
    assign bus.id_ex_rd      = rd_q;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage: a behavioural model of the stage
// (register array, control table, ID/EX contents) is advanced every clock
// and compared against the DUT on each falling edge, alongside directed
// scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic checkEn;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model of the architectural state the ID/EX register should hold
    logic [31:0] regs [32];
    logic [1:0]  mWb;
    logic [2:0]  mM;
    logic [3:0]  mEx;
    logic [31:0] mPc4, mRsData, mRtData, mImm;
    logic [4:0]  mRs, mRt, mRd;

    // Control table: {wb, m, ex} per opcode
    function automatic logic [8:0] ctrlFor(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b10_000_1100;
            6'h23:   return 9'b11_010_0001;
            6'h2B:   return 9'b00_001_0001;
            6'h04:   return 9'b00_100_0010;
            6'h08:   return 9'b10_000_0001;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic readsRt(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.wb_reg_write && bus.wb_rd == a) return bus.wb_data;
        return regs[a];
    endfunction

    // Expected stall for the instruction currently on IF/ID
    function automatic logic modelStall();
        logic [31:0] ins;
        logic        haz;
        ins = bus.if_id[31:0];
        haz = mM[1] && (mRt != 5'd0) &&
              ((mRt == ins[25:21]) || (readsRt(ins[31:26]) && mRt == ins[20:16]));
        return haz && !bus.flush;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        mWb = '0; mM = '0; mEx = '0;
        mPc4 = '0; mRsData = '0; mRtData = '0; mImm = '0;
        mRs = '0; mRt = '0; mRd = '0;
    endtask

    // Advance the model by one rising edge using the inputs held over it
    task automatic modelClock();
        logic [31:0] ins;
        logic [8:0]  c;
        logic        bub;
        if (!rst_n) begin
            clearModel();
        end else begin
            ins = bus.if_id[31:0];
            bub = bus.flush || modelStall();
            c   = bub ? 9'd0 : ctrlFor(ins[31:26]);
            mRsData = modelRead(ins[25:21]);
            mRtData = modelRead(ins[20:16]);
            mWb  = c[8:7];
            mM   = c[6:4];
            mEx  = c[3:0];
            mPc4 = bus.if_id[63:32];
            mImm = {{16{ins[15]}}, ins[15:0]};
            mRs  = ins[25:21];
            mRt  = ins[20:16];
            mRd  = ins[15:11];
            if (bus.wb_reg_write && bus.wb_rd != 5'd0) regs[bus.wb_rd] = bus.wb_data;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("stall",   32'(bus.stall),    32'(modelStall()));
            checkOutput("wb",      32'(bus.id_ex_wb), 32'(mWb));
            checkOutput("m",       32'(bus.id_ex_m),  32'(mM));
            checkOutput("ex",      32'(bus.id_ex_ex), 32'(mEx));
            checkOutput("pc4",     bus.id_ex_pc4,     mPc4);
            checkOutput("rs_data", bus.id_ex_rs_data, mRsData);
            checkOutput("rt_data", bus.id_ex_rt_data, mRtData);
            checkOutput("imm",     bus.id_ex_imm,     mImm);
            checkOutput("rs",      32'(bus.id_ex_rs), 32'(mRs));
            checkOutput("rt",      32'(bus.id_ex_rt), 32'(mRt));
            checkOutput("rd",      32'(bus.id_ex_rd), 32'(mRd));
        end
    end

    // Drive one cycle of inputs, sample stall, then clock the model
    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc4,
                                 input logic fl, input logic wbw,
                                 input logic [4:0] wbrd, input logic [31:0] wbdata,
                                 output logic stallSeen);
        bus.if_id        = {pc4, ins};
        bus.flush        = fl;
        bus.wb_reg_write = wbw;
        bus.wb_rd        = wbrd;
        bus.wb_data      = wbdata;
        @(negedge clk);
        stallSeen = bus.stall;
        @(posedge clk);
        modelClock();
        #1;
    endtask

    initial begin
        logic        st;
        logic [5:0]  opList [6];
        logic [5:0]  op;
        logic [31:0] ins;

        checks   = 0;
        failures = 0;
        checkEn  = 1'b0;
        rst_n    = 1'b0;
        bus.if_id = '0; bus.flush = 1'b0;
        bus.wb_reg_write = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        clearModel();
        checkEn = 1'b1;

        // Reset with garbage on the inputs
        applyStimulus(32'h8C220004, 32'h100, 1'b0, 1'b1, 5'd3, 32'h55, st);
        applyStimulus(32'h00432020, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0, st);
        checkOutput("reset_stall", 32'(st), 32'd0);
        checkOutput("reset_m", 32'(bus.id_ex_m), 32'd0);
        checkOutput("reset_pc4", bus.id_ex_pc4, 32'd0);
        rst_n = 1'b1;

        // Write-back bypass into add $3,$5,$6
        applyStimulus(32'h00A61820, 32'h200, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, st);
        checkOutput("bypass_rs_data", bus.id_ex_rs_data, 32'hDEADBEEF);
        checkOutput("bypass_ex", 32'(bus.id_ex_ex), 32'h0000000C);
        checkOutput("bypass_pc4", bus.id_ex_pc4, 32'h200);

        // Write to r0 must not stick or bypass; r5 now stored
        applyStimulus(32'h00A01820, 32'h204, 1'b0, 1'b1, 5'd0, 32'h1234, st);
        checkOutput("r5_stored", bus.id_ex_rs_data, 32'hDEADBEEF);
        checkOutput("r0_bypass", bus.id_ex_rt_data, 32'd0);
        applyStimulus(32'h00001820, 32'h208, 1'b0, 1'b0, 5'd0, 32'h0, st);
        checkOutput("r0_read", bus.id_ex_rs_data, 32'd0);

        // Load-use: lw $2,4($1) then add $4,$2,$3
        applyStimulus(32'h8C220004, 32'h300, 1'b0, 1'b0, 5'd0, 32'h0, st);
        checkOutput("lw_no_stall", 32'(st), 32'd0);
        checkOutput("lw_m", 32'(bus.id_ex_m), 32'h2);
        applyStimulus(32'h00432020, 32'h304, 1'b0, 1'b0, 5'd0, 32'h0, st);
        checkOutput("lu_stall", 32'(st), 32'd1);
        checkOutput("lu_bubble_ctrl", {23'd0, bus.id_ex_wb, bus.id_ex_m, bus.id_ex_ex}, 32'd0);
        applyStimulus(32'h00432020, 32'h304, 1'b0, 1'b0, 5'd0, 32'h0, st);
        checkOutput("lu_stall_once", 32'(st), 32'd0);
        checkOutput("lu_issue_rs", 32'(bus.id_ex_rs), 32'd2);
        checkOutput("lu_issue_ex", 32'(bus.id_ex_ex), 32'h0000000C);

        // lw followed by a dependent lw stalls once
        applyStimulus(32'h8C220004, 32'h310, 1'b0, 1'b0, 5'd0, 32'h0, st);
        applyStimulus(32'h8C450000, 32'h314, 1'b0, 1'b0, 5'd0, 32'h0, st);
        checkOutput("lwlw_stall", 32'(st), 32'd1);
        applyStimulus(32'h8C450000, 32'h314, 1'b0, 1'b0, 5'd0, 32'h0, st);
        checkOutput("lwlw_stall_once", 32'(st), 32'd0);

        // No false stalls: addi does not read rt; lw $0 never hazards
        applyStimulus(32'h8C220004, 32'h400, 1'b0, 1'b0, 5'd0, 32'h0, st);
        applyStimulus(32'h20E20005, 32'h404, 1'b0, 1'b0, 5'd0, 32'h0, st);
        checkOutput("addi_no_stall", 32'(st), 32'd0);
        applyStimulus(32'h8C200004, 32'h408, 1'b0, 1'b0, 5'd0, 32'h0, st);
        applyStimulus(32'h00032020, 32'h40C, 1'b0, 1'b0, 5'd0, 32'h0, st);
        checkOutput("lw_r0_no_stall", 32'(st), 32'd0);

        // Flush beats a simultaneous hazard
        applyStimulus(32'h8C220004, 32'h500, 1'b0, 1'b0, 5'd0, 32'h0, st);
        applyStimulus(32'h00432020, 32'h504, 1'b1, 1'b0, 5'd0, 32'h0, st);
        checkOutput("flush_no_stall", 32'(st), 32'd0);
        checkOutput("flush_bubble", {23'd0, bus.id_ex_wb, bus.id_ex_m, bus.id_ex_ex}, 32'd0);

        // Sign extension and unknown opcode
        applyStimulus(32'h20E2FFFC, 32'h600, 1'b0, 1'b0, 5'd0, 32'h0, st);
        checkOutput("imm_sext", bus.id_ex_imm, 32'hFFFFFFFC);
        checkOutput("addi_ex", 32'(bus.id_ex_ex), 32'd1);
        checkOutput("addi_wb", 32'(bus.id_ex_wb), 32'd2);
        applyStimulus(32'hFC000000, 32'h604, 1'b0, 1'b0, 5'd0, 32'h0, st);
        checkOutput("unknown_ctrl", {23'd0, bus.id_ex_wb, bus.id_ex_m, bus.id_ex_ex}, 32'd0);

        // Randomized traffic with small register indices to provoke hazards
        opList[0] = 6'h00; opList[1] = 6'h23; opList[2] = 6'h2B;
        opList[3] = 6'h04; opList[4] = 6'h08; opList[5] = 6'h3F;
        for (int n = 0; n < 400; n++) begin
            op  = opList[$urandom_range(0, 5)];
            if (op == 6'h3F) op = 6'($urandom_range(0, 63));
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            applyStimulus(ins, $urandom, ($urandom_range(0, 9) == 0), 1'($urandom),
                          5'($urandom_range(0, 9)), $urandom, st);
        end

        // Reset during a stall drops stall immediately
        applyStimulus(32'h8C220004, 32'h700, 1'b0, 1'b0, 5'd0, 32'h0, st);
        bus.if_id = {32'h704, 32'h00432020};
        #1;
        checkOutput("pre_reset_stall", 32'(bus.stall), 32'd1);
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOutput("reset_mid_stall", 32'(bus.stall), 32'd0);
        checkOutput("reset_mid_m", 32'(bus.id_ex_m), 32'd0);
        checkOutput("reset_mid_rt", 32'(bus.id_ex_rt), 32'd0);
        applyStimulus(32'h00432020, 32'h704, 1'b0, 1'b0, 5'd0, 32'h0, st);
        rst_n = 1'b1;

        // Every register reads zero after the clear
        for (int i = 1; i < 32; i++) begin
            ins = {6'h00, 5'(i), 5'(i), 16'h0000};
            applyStimulus(ins, 32'h800, 1'b0, 1'b0, 5'd0, 32'h0, st);
            checkOutput("cleared_reg", bus.id_ex_rs_data | bus.id_ex_rt_data, 32'd0);
        end

        @(negedge clk);
        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
